// File: rtl/cp0_regs_if.sv
// CP0 access bus between the pipeline and the coprocessor-0 register file.
// master: pipeline / interrupt-controller side (drives requests, sees results)
// slave : cp0_regs (consumes requests, returns dout, int_req, epc_out)
interface cp0_regs_if #(
    parameter int unsigned HW_INT_W = 6
);
    logic                we;
    logic [4:0]          addr;
    logic [31:0]         din;
    logic [31:0]         dout;
    logic [HW_INT_W-1:0] hw_int;
    logic [31:0]         pc_in;
    logic                bd_in;
    logic [4:0]          exc_code;
    logic                exl_set;
    logic                exl_clr;
    logic                int_req;
    logic [31:0]         epc_out;

    modport master (
        output we, addr, din, hw_int, pc_in, bd_in, exc_code, exl_set, exl_clr,
        input  dout, int_req, epc_out
    );

    modport slave (
        input  we, addr, din, hw_int, pc_in, bd_in, exc_code, exl_set, exl_clr,
        output dout, int_req, epc_out
    );
endinterface

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: SR(12), Cause(13), EPC(14), PrID(15).
// Ports:
//   clk  - clock, state updates on rising edge
//   rst  - synchronous active-high reset
//   bus  - cp0_regs_if.slave: mtc0/mfc0 access (we, addr, din, dout),
//          exception entry/exit (pc_in, bd_in, exc_code, exl_set, exl_clr),
//          interrupt lines (hw_int) and results (int_req, epc_out).
// dout and int_req are combinational from registered state; epc_out is a register.
module cp0_regs #(
    parameter int unsigned HW_INT_W = 6,
    parameter logic [31:0] PRID_VAL = 32'h4D4D_0001
) (
    input logic        clk,
    input logic        rst,
    cp0_regs_if.slave  bus
);
    localparam int unsigned IP_LSB   = 10;
    localparam logic [4:0]  ADDR_SR    = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE = 5'd13;
    localparam logic [4:0]  ADDR_EPC   = 5'd14;
    localparam logic [4:0]  ADDR_PRID  = 5'd15;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

    // SR fields
    logic [HW_INT_W-1:0] im_q;
    logic                exl_q;
    logic                ie_q;
    // Cause fields
    logic                bd_q;
    logic [HW_INT_W-1:0] ip_q;
    logic [4:0]          exc_code_q;
    // EPC, low two bits always zero
    logic [31:0]         epc_q;

    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic        int_req_c;
    logic [31:0] epc_entry;

    // Pending enabled interrupt, from registered state only
    assign int_req_c = (|(ip_q & im_q)) & ie_q & ~exl_q;

    // Faulting PC word-aligned; a delay-slot fault returns to the branch (wraps mod 2^32)
    assign epc_entry = (bus.pc_in & WORD_MASK) - (bus.bd_in ? 32'd4 : 32'd0);

    // Architectural register images
    always_comb begin
        sr_val                         = '0;
        sr_val[IP_LSB +: HW_INT_W]     = im_q;
        sr_val[1]                      = exl_q;
        sr_val[0]                      = ie_q;
        cause_val                      = '0;
        cause_val[31]                  = bd_q;
        cause_val[IP_LSB +: HW_INT_W]  = ip_q;
        cause_val[6:2]                 = exc_code_q;
    end

    // mfc0 read mux, no write bypass
    always_comb begin
        bus.dout = 32'h0;
        case (bus.addr)
            ADDR_SR:    bus.dout = sr_val;
            ADDR_CAUSE: bus.dout = cause_val;
            ADDR_EPC:   bus.dout = epc_q;
            ADDR_PRID:  bus.dout = PRID_VAL;
            default:    bus.dout = 32'h0;
        endcase
    end

    assign bus.int_req = int_req_c;
    assign bus.epc_out = epc_q;

    // State update: rst > exl_set (flushes mtc0) > exl_clr / mtc0 (SR write overrides exl_clr)
    always_ff @(posedge clk) begin
        if (rst) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= 5'd0;
            epc_q      <= 32'h0;
        end else begin
            ip_q <= bus.hw_int;
            if (bus.exl_set) begin
                exl_q      <= 1'b1;
                bd_q       <= bus.bd_in;
                epc_q      <= epc_entry;
                exc_code_q <= int_req_c ? 5'd0 : bus.exc_code;
            end else begin
                if (bus.exl_clr) begin
                    exl_q <= 1'b0;
                end
                if (bus.we && (bus.addr == ADDR_SR)) begin
                    im_q  <= bus.din[IP_LSB +: HW_INT_W];
                    exl_q <= bus.din[1];
                    ie_q  <= bus.din[0];
                end
                if (bus.we && (bus.addr == ADDR_EPC)) begin
                    epc_q <= bus.din & WORD_MASK;
                end
            end
        end
    end
endmodule
